column_render: RTL and testbench



---
 rtl/column_render.sv | 175 +++++++++++++++++
 tb/tb_column_render.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/column_render.sv
// Per-column wall renderer between vga_sync and the RGB/sync pins.
// Double-buffered height table filled by a tracer; front/back banks swap at the start of vblank.
module column_render #(
  parameter int unsigned H_VIEW    = 640,
  parameter int unsigned V_VIEW    = 480,
  parameter int unsigned COL_SHIFT = 2,
  parameter int unsigned HEIGHT_W  = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          h,
  input  logic [9:0]          v,
  input  logic                visible,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [7:0]          wr_col,
  input  logic [HEIGHT_W-1:0] wr_height,
  input  logic                wr_side,
  input  logic                wr_last,
  output logic [1:0]          red,
  output logic [1:0]          green,
  output logic [1:0]          blue,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start,
  output logic                frame_drop
);

  localparam int unsigned NCOL   = H_VIEW >> COL_SHIFT;
  localparam logic [9:0]  NCOL_C = 10'(NCOL);
  localparam logic [9:0]  V_SWAP = 10'(V_VIEW);
  localparam logic [10:0] V_MAX  = 11'(V_VIEW);
  localparam logic [10:0] V_HALF = 11'(V_VIEW / 2);

  typedef enum logic [0:0] {StFill, StCommitted} wr_state_e;

  wr_state_e state_q, state_d;
  logic      front_sel_q, front_sel_d;
  logic      front_valid_q, front_valid_d;
  logic      frame_start_q, frame_start_d;
  logic      frame_drop_q, frame_drop_d;

  // Entry layout: {side, height}
  logic [HEIGHT_W:0] bank_q [2][NCOL];

  logic [HEIGHT_W-1:0] s1_height_q, s1_height_d;
  logic                s1_side_q, s1_side_d;
  logic [9:0]          s1_v_q, s1_v_d;
  logic                s1_vis_q, s1_vis_d;
  logic                s1_hs_q, s1_hs_d;
  logic                s1_vs_q, s1_vs_d;
  logic [5:0]          rgb_q, rgb_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;

  logic              wr_accept;
  logic              swap_pt;
  logic              back_sel;
  logic [9:0]        col;
  logic              col_ok;
  logic [HEIGHT_W:0] rd_entry;
  logic [10:0]       hgt, half, top, bot, vv;
  logic              wall;

  assign wr_ready  = (state_q == StFill);
  assign wr_accept = wr_valid & wr_ready;
  assign swap_pt   = (h == 10'd0) && (v == V_SWAP);
  assign back_sel  = ~front_sel_q;

  // Write FSM and buffer swap
  always_comb begin
    state_d       = state_q;
    front_sel_d   = front_sel_q;
    front_valid_d = front_valid_q;
    frame_start_d = 1'b0;
    frame_drop_d  = 1'b0;
    unique case (state_q)
      StFill: begin
        if (swap_pt) frame_drop_d = 1'b1;
        if (wr_accept && wr_last) state_d = StCommitted;
      end
      StCommitted: begin
        if (swap_pt) begin
          state_d       = StFill;
          front_sel_d   = ~front_sel_q;
          front_valid_d = 1'b1;
          frame_start_d = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept && (10'(wr_col) < NCOL_C)) begin
      bank_q[back_sel][wr_col] <= {wr_side, wr_height};
    end
  end

  // Stage 1: front-bank read plus aligned v/visible/syncs
  always_comb begin
    col      = h >> COL_SHIFT;
    col_ok   = (col < NCOL_C);
    rd_entry = '0;
    if (col_ok && front_valid_q) rd_entry = bank_q[front_sel_q][col[7:0]];
    s1_height_d = rd_entry[HEIGHT_W-1:0];
    s1_side_d   = rd_entry[HEIGHT_W];
    s1_v_d      = v;
    s1_vis_d    = visible;
    s1_hs_d     = hsync_in;
    s1_vs_d     = vsync_in;
  end

  // Stage 2: wall span test and colour
  always_comb begin
    hgt = 11'(s1_height_q);
    if (hgt > V_MAX) hgt = V_MAX;
    half = hgt >> 1;
    top  = (V_HALF >= half) ? (V_HALF - half) : 11'd0;
    bot  = V_HALF + half;
    vv   = {1'b0, s1_v_q};
    wall = (vv >= top) && (vv < bot);
    if (!s1_vis_q)     rgb_d = 6'b00_00_00;
    else if (wall)     rgb_d = s1_side_q ? 6'b00_00_10 : 6'b01_01_11;
    else if (vv < V_HALF) rgb_d = 6'b01_01_01;
    else               rgb_d = 6'b00_01_00;
    hsync_d = s1_hs_q;
    vsync_d = s1_vs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFill;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      s1_height_q   <= '0;
      s1_side_q     <= 1'b0;
      s1_v_q        <= '0;
      s1_vis_q      <= 1'b0;
      s1_hs_q       <= 1'b1;
      s1_vs_q       <= 1'b1;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      front_sel_q   <= front_sel_d;
      front_valid_q <= front_valid_d;
      frame_start_q <= frame_start_d;
      frame_drop_q  <= frame_drop_d;
      s1_height_q   <= s1_height_d;
      s1_side_q     <= s1_side_d;
      s1_v_q        <= s1_v_d;
      s1_vis_q      <= s1_vis_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign red         = rgb_q[5:4];
  assign green       = rgb_q[3:2];
  assign blue        = rgb_q[1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_column_render.sv
// Directed bench for column_render: drives h/v directly and checks colours, syncs and buffer swaps.
module tb_column_render;

  localparam logic [5:0] CEIL  = 6'b01_01_01;
  localparam logic [5:0] FLOOR = 6'b00_01_00;
  localparam logic [5:0] WALL0 = 6'b01_01_11;
  localparam logic [5:0] WALL1 = 6'b00_00_10;
  localparam logic [5:0] BLACK = 6'b00_00_00;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] h, v;
  logic       visible, hsync_in, vsync_in;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_col;
  logic [8:0] wr_height;
  logic       wr_side, wr_last;
  logic [1:0] red, green, blue;
  logic       hsync, vsync, frame_start, frame_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  column_render dut (
    .clk        (clk),
    .reset      (reset),
    .h          (h),
    .v          (v),
    .visible    (visible),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_col     (wr_col),
    .wr_height  (wr_height),
    .wr_side    (wr_side),
    .wr_last    (wr_last),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .frame_drop (frame_drop)
  );

  task automatic set_idle();
    h = 10'd1; v = 10'd500; visible = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
  endtask

  // One pixel in, idle after it, colour observed two clocks later
  task automatic pixel(input int ph, input int pv, input logic pvis, output logic [5:0] rgb);
    @(negedge clk); h = 10'(ph); v = 10'(pv); visible = pvis;
    @(negedge clk); set_idle();
    @(negedge clk); rgb = {red, green, blue};
  endtask

  // Swap point; returns {frame_start, frame_drop} during the pulse cycle and one cycle later
  task automatic swap(output logic [1:0] pulse, output logic [1:0] after);
    @(negedge clk); h = 10'd0; v = 10'd480; visible = 1'b0;
    @(negedge clk); pulse = {frame_start, frame_drop}; set_idle();
    @(negedge clk); after = {frame_start, frame_drop};
  endtask

  task automatic wr(input int col, input int hgt, input logic side, input logic last);
    @(negedge clk);
    wr_valid = 1'b1; wr_col = 8'(col); wr_height = 9'(hgt); wr_side = side; wr_last = last;
    @(negedge clk); wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr_col = '0; wr_height = '0; wr_side = 1'b0; wr_last = 1'b0;
    h = 10'd0; v = 10'd0; visible = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({red, green, blue, hsync, vsync, frame_start, frame_drop} !== {BLACK, 4'b1100}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b",
               {red, green, blue, hsync, vsync, frame_start, frame_drop}, {BLACK, 4'b1100});
    end
    reset = 1'b0; set_idle();
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_background();
    int px [5] = '{0, 300, 300, 639, 100};
    int py [5] = '{0, 239, 240, 479, 100};
    logic pv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] exp [5] = '{CEIL, CEIL, FLOOR, FLOOR, BLACK};
    logic [5:0] rgb;
    logic [1:0] p, a;
    for (int i = 0; i < 5; i++) begin
      pixel(px[i], py[i], pv[i], rgb);
      n_cmp++;
      if (rgb !== exp[i]) begin
        n_bad++; $display("FAIL bg_pixel_%0d: got %b want %b", i, rgb, exp[i]);
      end
    end
    for (int f = 0; f < 2; f++) begin
      swap(p, a);
      n_cmp++;
      if ({p, a} !== 4'b0100) begin
        n_bad++; $display("FAIL bg_drop_%0d: got %b want 0100", f, {p, a});
      end
    end
  endtask

  task automatic test_sync_latency();
    logic [5:0] rgb;
    int px [4] = '{639, 640, 799, 0};
    logic pv [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0] exp [4] = '{CEIL, BLACK, BLACK, CEIL};
    @(negedge clk); hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk); hsync_in = 1'b1; vsync_in = 1'b1;
    n_cmp++;
    if ({hsync, vsync} !== 2'b11) begin n_bad++; $display("FAIL sync_n1: got %b want 11", {hsync, vsync}); end
    @(negedge clk);
    n_cmp++;
    if ({hsync, vsync} !== 2'b00) begin n_bad++; $display("FAIL sync_n2: got %b want 00", {hsync, vsync}); end
    @(negedge clk);
    n_cmp++;
    if ({hsync, vsync} !== 2'b11) begin n_bad++; $display("FAIL sync_n3: got %b want 11", {hsync, vsync}); end
    for (int i = 0; i < 4; i++) begin
      pixel(px[i], 100, pv[i], rgb);
      n_cmp++;
      if (rgb !== exp[i]) begin n_bad++; $display("FAIL blank_%0d: got %b want %b", i, rgb, exp[i]); end
    end
  endtask

  task automatic test_fill_swap();
    int px [6] = '{0, 0, 320, 320, 639, 4};
    int py [6] = '{189, 190, 289, 290, 240, 100};
    logic [5:0] exp [6] = '{CEIL, WALL0, WALL0, FLOOR, WALL0, CEIL};
    logic [5:0] rgb;
    logic [1:0] p, a;
    for (int i = 0; i < 160; i++) wr(i, 100, 1'b0, (i == 159));
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL commit_ready: got %b want 0", wr_ready); end
    swap(p, a);
    n_cmp++;
    if ({p, a} !== 4'b1000) begin n_bad++; $display("FAIL fill_swap: got %b want 1000", {p, a}); end
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL swap_ready: got %b want 1", wr_ready); end
    for (int i = 0; i < 6; i++) begin
      pixel(px[i], py[i], 1'b1, rgb);
      n_cmp++;
      if (rgb !== exp[i]) begin n_bad++; $display("FAIL fill_pixel_%0d: got %b want %b", i, rgb, exp[i]); end
    end
    // Write to the back bank must not disturb the displayed column
    wr(0, 480, 1'b0, 1'b0);
    pixel(0, 0, 1'b1, rgb);
    n_cmp++;
    if (rgb !== CEIL) begin n_bad++; $display("FAIL front_untouched: got %b want %b", rgb, CEIL); end
  endtask

  task automatic test_edge_heights();
    int px [8] = '{20, 23, 24, 24, 28, 31, 0, 3};
    int py [8] = '{0, 479, 0, 240, 0, 479, 0, 240};
    logic [5:0] exp [8] = '{WALL1, WALL1, CEIL, FLOOR, WALL0, WALL0, WALL0, WALL0};
    logic [5:0] rgb;
    logic [1:0] p, a;
    wr(5, 480, 1'b1, 1'b0);
    wr(6, 480, 1'b0, 1'b0);
    wr(6, 0, 1'b0, 1'b0);
    wr(200, 480, 1'b1, 1'b0);
    wr(7, 511, 1'b0, 1'b1);
    swap(p, a);
    n_cmp++;
    if ({p, a} !== 4'b1000) begin n_bad++; $display("FAIL edge_swap: got %b want 1000", {p, a}); end
    for (int i = 0; i < 8; i++) begin
      pixel(px[i], py[i], 1'b1, rgb);
      n_cmp++;
      if (rgb !== exp[i]) begin n_bad++; $display("FAIL edge_pixel_%0d: got %b want %b", i, rgb, exp[i]); end
    end
  endtask

  task automatic test_last_at_swap();
    int px [4] = '{40, 44, 28, 28};
    int py [4] = '{0, 0, 0, 200};
    logic [5:0] exp [4] = '{WALL1, WALL1, CEIL, WALL0};
    logic [5:0] rgb;
    logic [1:0] p, a;
    wr(10, 480, 1'b1, 1'b0);
    @(negedge clk);
    h = 10'd0; v = 10'd480; visible = 1'b0;
    wr_valid = 1'b1; wr_col = 8'd11; wr_height = 9'd480; wr_side = 1'b1; wr_last = 1'b1;
    @(negedge clk);
    p = {frame_start, frame_drop};
    set_idle(); wr_valid = 1'b0; wr_last = 1'b0;
    n_cmp++;
    if (p !== 2'b01) begin n_bad++; $display("FAIL late_last_drop: got %b want 01", p); end
    n_cmp++;
    if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL late_last_ready: got %b want 0", wr_ready); end
    pixel(28, 0, 1'b1, rgb);
    n_cmp++;
    if (rgb !== WALL0) begin n_bad++; $display("FAIL late_last_old_front: got %b want %b", rgb, WALL0); end
    swap(p, a);
    n_cmp++;
    if ({p, a} !== 4'b1000) begin n_bad++; $display("FAIL late_last_swap: got %b want 1000", {p, a}); end
    for (int i = 0; i < 4; i++) begin
      pixel(px[i], py[i], 1'b1, rgb);
      n_cmp++;
      if (rgb !== exp[i]) begin n_bad++; $display("FAIL late_pixel_%0d: got %b want %b", i, rgb, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int px [3] = '{0, 639, 320};
    int py [3] = '{0, 479, 240};
    logic [5:0] rgb;
    logic [1:0] p, a;
    for (int i = 0; i < 10; i++) wr(i, 480, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; h = 10'd0; v = 10'd0; visible = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({red, green, blue, hsync, vsync, frame_start, frame_drop} !== {BLACK, 4'b1100}) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b want %b",
               {red, green, blue, hsync, vsync, frame_start, frame_drop}, {BLACK, 4'b1100});
    end
    reset = 1'b0; set_idle();
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", wr_ready); end
    pixel(40, 0, 1'b1, rgb);
    n_cmp++;
    if (rgb !== CEIL) begin n_bad++; $display("FAIL midreset_no_front: got %b want %b", rgb, CEIL); end
    for (int i = 0; i < 160; i++) wr(i, 480, 1'b1, (i == 159));
    swap(p, a);
    n_cmp++;
    if ({p, a} !== 4'b1000) begin n_bad++; $display("FAIL refill_swap: got %b want 1000", {p, a}); end
    for (int i = 0; i < 3; i++) begin
      pixel(px[i], py[i], 1'b1, rgb);
      n_cmp++;
      if (rgb !== WALL1) begin n_bad++; $display("FAIL refill_pixel_%0d: got %b want %b", i, rgb, WALL1); end
    end
  endtask

  initial begin
    test_reset();
    test_background();
    test_sync_latency();
    test_fill_swap();
    test_edge_heights();
    test_last_at_swap();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
